// File: rtl/dmi_access_ctrl.sv
// DMI access controller on the JTAG-DTM side of the DMI-to-TileLink bridge.
// Each accepted Update-DR becomes one DMI request/response transaction.
// The controller keeps the sticky dmistat (busy/failed) and the value that
// the next Capture-DR returns.
module dmi_access_ctrl #(
    parameter int ABITS = 7,
    parameter int DBITS = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   io_update_valid,
    input  logic [ABITS-1:0]       io_update_addr,
    input  logic [DBITS-1:0]       io_update_data,
    input  logic [1:0]             io_update_op,
    input  logic                   io_capture,
    output logic [ABITS+DBITS+1:0] io_capture_bits,
    input  logic                   io_dmireset,
    input  logic                   io_dmihardreset,
    output logic [1:0]             io_dmistat,
    output logic                   io_busy,
    input  logic                   io_dmi_req_ready,
    output logic                   io_dmi_req_valid,
    output logic [ABITS-1:0]       io_dmi_req_bits_addr,
    output logic [DBITS-1:0]       io_dmi_req_bits_data,
    output logic [1:0]             io_dmi_req_bits_op,
    output logic                   io_dmi_resp_ready,
    input  logic                   io_dmi_resp_valid,
    input  logic [DBITS-1:0]       io_dmi_resp_bits_data,
    input  logic [1:0]             io_dmi_resp_bits_resp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_READ   = 2'd1;
    localparam logic [1:0] OP_WRITE  = 2'd2;
    localparam logic [1:0] ST_OK     = 2'd0;
    localparam logic [1:0] ST_FAILED = 2'd2;
    localparam logic [1:0] ST_BUSY   = 2'd3;

    state_t                 state_r;
    logic [ABITS-1:0]       addr_r;
    logic [DBITS-1:0]       data_r;
    logic [1:0]             op_r;
    logic [1:0]             dmistat_r;
    logic [ABITS+DBITS+1:0] capture_bits_r;
    logic                   req_valid_r;
    logic                   resp_ready_r;
    logic                   busy_r;
    logic                   discard_r;

    logic       clear_s;
    logic       stat_ok_s;
    logic       req_op_s;
    logic       accept_s;
    logic       req_fire_s;
    logic       resp_fire_s;
    logic       drop_s;
    logic       busy_event_s;
    logic       fail_event_s;
    logic [1:0] cap_status_s;

    // Decode this cycle's events; a same-cycle dmireset lets an IDLE update see a clean status.
    always_comb begin
        clear_s      = io_dmireset | io_dmihardreset;
        stat_ok_s    = clear_s | (dmistat_r == ST_OK);
        req_op_s     = (io_update_op == OP_READ) | (io_update_op == OP_WRITE);
        accept_s     = (state_r == IDLE) & io_update_valid & req_op_s & stat_ok_s;
        req_fire_s   = (state_r == REQ) & req_valid_r & io_dmi_req_ready;
        resp_fire_s  = (state_r == RESP) & resp_ready_r & io_dmi_resp_valid;
        drop_s       = discard_r | io_dmihardreset;
        busy_event_s = (state_r != IDLE) & (io_update_valid | io_capture);
        fail_event_s = resp_fire_s & (io_dmi_resp_bits_resp != 2'd0) & ~drop_s;
        if (state_r != IDLE) begin
            cap_status_s = ST_BUSY;
        end else begin
            cap_status_s = dmistat_r;
        end
    end

    // Transaction FSM: one request, held until accepted, then one response drained.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            addr_r       <= '0;
            data_r       <= '0;
            op_r         <= 2'd0;
            req_valid_r  <= 1'b0;
            resp_ready_r <= 1'b0;
            busy_r       <= 1'b0;
            discard_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        addr_r      <= io_update_addr;
                        data_r      <= io_update_data;
                        op_r        <= io_update_op;
                        state_r     <= REQ;
                        req_valid_r <= 1'b1;
                        busy_r      <= 1'b1;
                        discard_r   <= 1'b0;
                    end
                end
                REQ: begin
                    // A hard reset cannot retract valid; the result is dropped later instead.
                    if (io_dmihardreset) begin
                        discard_r <= 1'b1;
                    end
                    if (req_fire_s) begin
                        state_r      <= RESP;
                        req_valid_r  <= 1'b0;
                        resp_ready_r <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_fire_s) begin
                        if (!drop_s && (op_r == OP_READ) && (io_dmi_resp_bits_resp == 2'd0)) begin
                            data_r <= io_dmi_resp_bits_data;
                        end
                        state_r      <= IDLE;
                        resp_ready_r <= 1'b0;
                        busy_r       <= 1'b0;
                        discard_r    <= 1'b0;
                    end else if (io_dmihardreset) begin
                        discard_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    req_valid_r  <= 1'b0;
                    resp_ready_r <= 1'b0;
                    busy_r       <= 1'b0;
                    discard_r    <= 1'b0;
                end
            endcase
        end
    end

    // Sticky status: a clear wins, otherwise only an OK status can become failed or busy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dmistat_r <= ST_OK;
        end else if (clear_s) begin
            dmistat_r <= ST_OK;
        end else if (dmistat_r == ST_OK) begin
            if (fail_event_s) begin
                dmistat_r <= ST_FAILED;
            end else if (busy_event_s) begin
                dmistat_r <= ST_BUSY;
            end
        end
    end

    // Capture snapshot uses the registers as they were before this cycle's update/response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            capture_bits_r <= '0;
        end else if (io_capture) begin
            capture_bits_r <= {addr_r, data_r, cap_status_s};
        end
    end

    assign io_capture_bits      = capture_bits_r;
    assign io_dmistat           = dmistat_r;
    assign io_busy              = busy_r;
    assign io_dmi_req_valid     = req_valid_r;
    assign io_dmi_req_bits_addr = addr_r;
    assign io_dmi_req_bits_data = data_r;
    assign io_dmi_req_bits_op   = op_r;
    assign io_dmi_resp_ready    = resp_ready_r;

endmodule

// File: tb/tb_dmi_access_ctrl.sv
// Bench for dmi_access_ctrl: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model.
module tb_dmi_access_ctrl;

    logic        clock;
    logic        reset;
    logic        io_update_valid;
    logic [6:0]  io_update_addr;
    logic [31:0] io_update_data;
    logic [1:0]  io_update_op;
    logic        io_capture;
    logic [40:0] io_capture_bits;
    logic        io_dmireset;
    logic        io_dmihardreset;
    logic [1:0]  io_dmistat;
    logic        io_busy;
    logic        io_dmi_req_ready;
    logic        io_dmi_req_valid;
    logic [6:0]  io_dmi_req_bits_addr;
    logic [31:0] io_dmi_req_bits_data;
    logic [1:0]  io_dmi_req_bits_op;
    logic        io_dmi_resp_ready;
    logic        io_dmi_resp_valid;
    logic [31:0] io_dmi_resp_bits_data;
    logic [1:0]  io_dmi_resp_bits_resp;

    dmi_access_ctrl #(.ABITS(7), .DBITS(32)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .io_update_valid       (io_update_valid),
        .io_update_addr        (io_update_addr),
        .io_update_data        (io_update_data),
        .io_update_op          (io_update_op),
        .io_capture            (io_capture),
        .io_capture_bits       (io_capture_bits),
        .io_dmireset           (io_dmireset),
        .io_dmihardreset       (io_dmihardreset),
        .io_dmistat            (io_dmistat),
        .io_busy               (io_busy),
        .io_dmi_req_ready      (io_dmi_req_ready),
        .io_dmi_req_valid      (io_dmi_req_valid),
        .io_dmi_req_bits_addr  (io_dmi_req_bits_addr),
        .io_dmi_req_bits_data  (io_dmi_req_bits_data),
        .io_dmi_req_bits_op    (io_dmi_req_bits_op),
        .io_dmi_resp_ready     (io_dmi_resp_ready),
        .io_dmi_resp_valid     (io_dmi_resp_valid),
        .io_dmi_resp_bits_data (io_dmi_resp_bits_data),
        .io_dmi_resp_bits_resp (io_dmi_resp_bits_resp)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a transaction is outstanding, its request may have been
    // handed over, and its result may have been abandoned.
    bit          m_out;
    bit          m_handed;
    bit          m_abandon;
    logic [6:0]  m_addr;
    logic [31:0] m_data;
    logic [1:0]  m_op;
    logic [1:0]  m_stat;
    logic [40:0] m_cap;

    // Free-running clock, period 10.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out = 1'b0; m_handed = 1'b0; m_abandon = 1'b0;
        m_addr = 7'h0; m_data = 32'h0; m_op = 2'd0; m_stat = 2'd0; m_cap = 41'h0;
    endtask

    task automatic compare_all();
        check("req_valid", io_dmi_req_valid, m_out && !m_handed);
        check("resp_ready", io_dmi_resp_ready, m_out && m_handed);
        check("busy", io_busy, m_out);
        check("dmistat", io_dmistat, m_stat);
        check("capture_bits", io_capture_bits, m_cap);
        if (m_out && !m_handed) begin
            check("req_addr", io_dmi_req_bits_addr, m_addr);
            check("req_data", io_dmi_req_bits_data, m_data);
            check("req_op", io_dmi_req_bits_op, m_op);
        end
    endtask

    // One clock cycle: check outputs, drive inputs, advance the model.
    task automatic step(input bit u, input logic [1:0] op, input logic [6:0] ua, input logic [31:0] ud,
                        input bit cap, input bit dr, input bit dhr, input bit rdy,
                        input bit rv, input logic [31:0] rd, input logic [1:0] rr);
        bit          busy_pre;
        bit          clear;
        bit          drop;
        bit          req_fire;
        bit          resp_fire;
        logic [1:0]  new_stat;
        @(negedge clock);
        compare_all();
        io_update_valid = u; io_update_op = op; io_update_addr = ua; io_update_data = ud;
        io_capture = cap; io_dmireset = dr; io_dmihardreset = dhr; io_dmi_req_ready = rdy;
        io_dmi_resp_valid = rv; io_dmi_resp_bits_data = rd; io_dmi_resp_bits_resp = rr;

        busy_pre  = m_out;
        clear     = dr || dhr;
        drop      = m_abandon || dhr;
        req_fire  = m_out && !m_handed && rdy;
        resp_fire = m_out && m_handed && rv;
        if (cap) m_cap = {m_addr, m_data, busy_pre ? 2'd3 : m_stat};
        new_stat = m_stat;
        if (clear) new_stat = 2'd0;
        else if (m_stat == 2'd0) begin
            if (resp_fire && rr != 2'd0 && !drop) new_stat = 2'd2;
            else if (busy_pre && (u || cap)) new_stat = 2'd3;
        end
        if (!busy_pre) begin
            if (u && (op == 2'd1 || op == 2'd2) && (clear || m_stat == 2'd0)) begin
                m_addr = ua; m_data = ud; m_op = op;
                m_out = 1'b1; m_handed = 1'b0; m_abandon = 1'b0;
            end
        end else if (resp_fire) begin
            if (!drop && m_op == 2'd1 && rr == 2'd0) m_data = rd;
            m_out = 1'b0; m_abandon = 1'b0;
        end else begin
            if (req_fire) m_handed = 1'b1;
            if (dhr) m_abandon = 1'b1;
        end
        m_stat = new_stat;
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 2'd0, 7'h0, 32'h0, 1'b0, 1'b0, 1'b0, rdy, 1'b0, 32'h0, 2'd0);
    endtask

    task automatic update(input logic [1:0] op, input logic [6:0] ua, input logic [31:0] ud);
        step(1'b1, op, ua, ud, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
    endtask

    task automatic resp(input logic [31:0] rd, input logic [1:0] rr);
        step(1'b0, 2'd0, 7'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rd, rr);
    endtask

    task automatic capture();
        step(1'b0, 2'd0, 7'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
    endtask

    task automatic dmireset();
        step(1'b0, 2'd0, 7'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
    endtask

    task automatic clear_inputs();
        io_update_valid = 1'b0; io_update_op = 2'd0; io_update_addr = 7'h0; io_update_data = 32'h0;
        io_capture = 1'b0; io_dmireset = 1'b0; io_dmihardreset = 1'b0; io_dmi_req_ready = 1'b0;
        io_dmi_resp_valid = 1'b0; io_dmi_resp_bits_data = 32'h0; io_dmi_resp_bits_resp = 2'd0;
    endtask

    // Reset asserted between clock edges; outputs must clear without waiting for a clock.
    task automatic async_reset();
        @(negedge clock);
        clear_inputs();
        #2;
        reset = 1'b1;
        #1;
        check("arst_req_valid", io_dmi_req_valid, 1'b0);
        check("arst_resp_ready", io_dmi_resp_ready, 1'b0);
        check("arst_busy", io_busy, 1'b0);
        check("arst_dmistat", io_dmistat, 2'd0);
        check("arst_capture", io_capture_bits, 41'h0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        bit          u, cap, dr, dhr, rdy, rv;
        logic [1:0]  op, rr;
        logic [6:0]  ua;
        logic [31:0] ud, rd;

        reset = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        idle(1'b0);

        // Read OK with a three-cycle response latency.
        update(2'd1, 7'h11, 32'h0);
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);
        resp(32'hDEADBEEF, 2'd0);
        idle(1'b0);
        capture();
        idle(1'b0);
        check("read_capture", io_capture_bits, {7'h11, 32'hDEADBEEF, 2'b00});

        // Write held off by five cycles of backpressure.
        update(2'd2, 7'h10, 32'h1);
        repeat (5) idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        resp(32'hFFFFFFFF, 2'd0);
        capture();
        idle(1'b0);
        check("write_capture", io_capture_bits, {7'h10, 32'h1, 2'b00});

        // Update while a transaction is in flight sets busy; busy blocks later updates.
        update(2'd1, 7'h21, 32'h0);
        idle(1'b1);
        update(2'd1, 7'h22, 32'h0);
        resp(32'hCAFE0001, 2'd0);
        capture();
        idle(1'b0);
        check("busy_stat", io_dmistat, 2'd3);
        check("busy_capture", io_capture_bits, {7'h21, 32'hCAFE0001, 2'b11});
        update(2'd1, 7'h23, 32'h0);
        idle(1'b0);
        check("busy_blocks", io_busy, 1'b0);
        dmireset();
        update(2'd1, 7'h24, 32'h0);
        idle(1'b1);
        check("after_dmireset_busy", io_busy, 1'b1);
        resp(32'h00000024, 2'd0);

        // Failed response keeps data and blocks the next write until dmireset.
        update(2'd1, 7'h30, 32'h0);
        idle(1'b1);
        resp(32'h12345678, 2'd1);
        idle(1'b0);
        check("failed_stat", io_dmistat, 2'd2);
        update(2'd2, 7'h31, 32'h9);
        idle(1'b0);
        check("failed_no_req", io_dmi_req_valid, 1'b0);
        dmireset();

        // Hard reset while the request is stalled: handshake completes, result dropped.
        update(2'd1, 7'h40, 32'h0);
        idle(1'b0);
        step(1'b0, 2'd0, 7'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0);
        idle(1'b1);
        resp(32'h00000055, 2'd0);
        capture();
        idle(1'b0);
        check("hardreset_capture", io_capture_bits, {7'h40, 32'h00000000, 2'b00});
        check("hardreset_busy", io_busy, 1'b0);

        // Asynchronous reset in the response phase, then a normal read.
        update(2'd1, 7'h50, 32'h0);
        idle(1'b1);
        idle(1'b0);
        async_reset();
        update(2'd1, 7'h51, 32'h0);
        idle(1'b1);
        resp(32'hA5A5A5A5, 2'd0);
        capture();
        idle(1'b0);
        check("post_reset_capture", io_capture_bits, {7'h51, 32'hA5A5A5A5, 2'b00});

        // Random traffic with a well-behaved bridge.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end
            u   = ($urandom_range(0, 3) == 0);
            op  = 2'($urandom);
            ua  = 7'($urandom);
            ud  = $urandom;
            cap = ($urandom_range(0, 4) == 0);
            dr  = ($urandom_range(0, 19) == 0);
            dhr = ($urandom_range(0, 29) == 0);
            rdy = ($urandom_range(0, 1) == 0);
            rv  = m_out && m_handed && ($urandom_range(0, 2) == 0);
            rd  = $urandom;
            rr  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            step(u, op, ua, ud, cap, dr, dhr, rdy, rv, rd, rr);
        end
        idle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmi_access_ctrl.md
Name: dmi_access_ctrl

Overview:
JTAG-DTM-side DMI access controller, directly upstream of the DMI-to-TileLink bridge. Turns DMI data-register update/capture strobes into single DMI request/response transactions on the bridge's io_dmi_req/io_dmi_resp ports. Tracks sticky busy/failed status per the RISC-V debug spec dmistat rules. Holds the value returned on the next capture.

Parameters:
ABITS, 7, DMI address width; must match bridge io_dmi_req_bits_addr.
DBITS, 32, DMI data width.

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-high reset
io_update_valid  in  1  one-cycle pulse: JTAG Update-DR of the dmi register
io_update_addr  in  ABITS  address field of the shifted value
io_update_data  in  DBITS  data field of the shifted value
io_update_op  in  2  op field: 0 nop, 1 read, 2 write, 3 reserved
io_capture  in  1  one-cycle pulse: JTAG Capture-DR of the dmi register
io_capture_bits  out  ABITS+DBITS+2  {addr, data, status}, registered
io_dmireset  in  1  pulse: clear sticky status
io_dmihardreset  in  1  pulse: clear sticky status and abandon the result
io_dmistat  out  2  sticky status: 0 ok, 2 failed, 3 busy
io_busy  out  1  high when state != IDLE
io_dmi_req_ready  in  1  from bridge
io_dmi_req_valid  out  1  to bridge
io_dmi_req_bits_addr  out  ABITS
io_dmi_req_bits_data  out  DBITS
io_dmi_req_bits_op  out  2  1 read, 2 write only
io_dmi_resp_ready  out  1  to bridge
io_dmi_resp_valid  in  1  from bridge
io_dmi_resp_bits_data  in  DBITS
io_dmi_resp_bits_resp  in  2  0 ok, nonzero failed

Behaviour:
- Reset (async assert, sync deassert assumed): state IDLE. addr_reg, data_reg, dmistat, io_capture_bits = 0. io_dmi_req_valid = 0, io_dmi_resp_ready = 0, io_busy = 0, discard flag = 0.
- States: IDLE, REQ, RESP.
- IDLE, update pulse, op 1 or 2, dmistat == 0:
  - latch addr/data/op into addr_reg/data_reg/op_reg.
  - go to REQ; io_dmi_req_valid is high the next cycle (1-cycle latency).
- IDLE, update pulse, op 0 or 3: no request; addr_reg/data_reg unchanged.
- IDLE, update pulse, dmistat != 0: update ignored, no request, registers unchanged.
- REQ:
  - req_valid held high with req_bits stable (driven from registers) until req_ready.
  - On fire (valid & ready): go to RESP next cycle. req_valid must not drop before fire.
- RESP:
  - io_dmi_resp_ready = 1.
  - On resp_valid: op_reg == read and resp == 0 → data_reg <= resp data.
  - On resp_valid: resp != 0 and dmistat == 0 → dmistat <= 2.
  - Then IDLE next cycle. Write responses never change data_reg.
- Update pulse while state != IDLE: ignored, and dmistat <= 3 unless already nonzero.
- Capture pulse:
  - io_capture_bits <= {addr_reg, data_reg, s}, valid the next cycle.
  - s = 3 if state != IDLE, else dmistat.
  - Capture while state != IDLE also sets dmistat <= 3 if it was 0.
  - If resp fires in the same cycle as capture, s uses the pre-response state, i.e. reports 3.
- Sticky precedence: the first nonzero status wins. Failed is never overwritten by busy, and busy is never overwritten by failed.
- io_dmireset pulse: dmistat <= 0 next cycle; an in-flight transaction continues.
  - Same cycle as a busy-setting event: the clear wins.
  - Same cycle as an update in IDLE: the update is evaluated with dmistat treated as 0.
- io_dmihardreset pulse:
  - dmistat <= 0; an outstanding transaction is abandoned.
  - The req handshake still completes: valid is held until fire, because TL-A forbids dropping valid.
  - The response is drained with resp_ready high, and its data/resp are discarded via the discard flag.
  - Discard flag clears on return to IDLE.
- Async reset mid-transaction: immediate return to reset values; req_valid drops asynchronously.
- Update and capture in the same cycle: capture reports pre-update registers; the update is processed normally.

Test Plan:
- Read ok: update op=1 addr=0x11, bridge ready, resp data=0xDEADBEEF resp=0 after 3 cycles → req_valid the cycle after update; capture after IDLE = {0x11, 0xDEADBEEF, 0}.
- Write with backpressure: update op=2 addr=0x10 data=0x1, req_ready low for 5 cycles → req_valid/bits stable 5 cycles, single fire; data_reg stays 0x1; capture status 0.
- Busy: update op=1 while in RESP → second update ignored, dmistat=3; capture status 3; later op=1 update ignored until dmireset pulse, then accepted.
- Failed: resp=1 on a read → dmistat=2, data_reg unchanged; next op=2 update issues no request; dmireset → dmistat 0.
- Hardreset mid-REQ: dmihardreset while req stalled → dmistat 0; req still fires once; resp (data 0x55) drained and discarded, data_reg unchanged; io_busy low after drain.
- Async reset during RESP: assert reset → req_valid/resp_ready 0 immediately, capture_bits 0, dmistat 0; post-reset read works normally.
